data_mem_responder: RTL and testbench

Responder end of the core's data-memory request interface: accepts one load/store request at a time from the load/store unit, checks alignment and bounds, performs the access on an internal word-organised array, and returns read data plus a `mem_errors_e` status. It uses `mem_access_type_e` for request width and `mem_errors_e` for response status. Loaded data is returned right-justified and zero-extended. The core's SX stage applies sign extension for LB/LH.

---
 rtl/data_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-request data-memory responder with
// alignment/bounds checks over a word-organised array.
package data_mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_access_type_e;

  typedef enum logic [1:0] {
    NO_MEM_ERROR       = 2'b00,
    ADDRESS_MISALIGNED = 2'b01,
    OUT_OF_BOUNDS      = 2'b10
  } mem_errors_e;
endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int AW = IDX_W + 2;
  localparam logic [32:0] ADDR_LIM = 33'(MEM_WORDS) << 2;
  localparam int CNT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [2:0] CNT_INIT = 3'(CNT_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            r_state;
  state_e            w_state_nx;
  logic [2:0]        r_cnt;
  logic              r_write;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_wdata;
  mem_access_type_e  r_type;
  mem_errors_e       r_err;
  logic [31:0]       r_rdata;
  mem_errors_e       r_rsp_err;
  logic [31:0]       r_mem [MEM_WORDS];

  mem_access_type_e  w_req_type;
  mem_errors_e       w_req_err;
  logic              w_mis;
  logic              w_accept;
  logic              w_imm;
  logic              w_commit;
  logic              w_c_write;
  logic [AW-1:0]     w_c_addr;
  logic [31:0]       w_c_wdata;
  mem_access_type_e  w_c_type;
  mem_errors_e       w_c_err;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wd_sh;
  logic [31:0]       w_word;
  logic [31:0]       w_rd_sh;
  logic [31:0]       w_ld;
  logic              w_we;

  assign w_req_type = mem_access_type_e'(req_type);
  assign w_accept   = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_mis = 1'b0;
    unique case (w_req_type)
      MEM_BYTE: w_mis = 1'b0;
      MEM_HALF: w_mis = req_addr[0];
      MEM_WORD: w_mis = |req_addr[1:0];
      default:  w_mis = 1'b1;
    endcase
    w_req_err = NO_MEM_ERROR;
    if (w_mis)
      w_req_err = ADDRESS_MISALIGNED;
    else if ({1'b0, req_addr} >= ADDR_LIM)
      w_req_err = OUT_OF_BOUNDS;
  end

  // zero latency commits straight from the request inputs
  assign w_imm     = (r_state == S_IDLE);
  assign w_c_write = w_imm ? req_write : r_write;
  assign w_c_addr  = w_imm ? req_addr[AW-1:0] : r_addr;
  assign w_c_wdata = w_imm ? req_wdata : r_wdata;
  assign w_c_type  = w_imm ? w_req_type : r_type;
  assign w_c_err   = w_imm ? w_req_err : r_err;
  assign w_commit  = (LATENCY == 0) ? w_accept
                   : ((r_state == S_WAIT) && (r_cnt == 3'd0));

  assign w_idx   = w_c_addr[AW-1:2];
  assign w_lane  = w_c_addr[1:0];
  assign w_wd_sh = w_c_wdata << {w_lane, 3'b000};
  assign w_word  = r_mem[w_idx];
  assign w_rd_sh = w_word >> {w_lane, 3'b000};
  assign w_we    = w_commit && w_c_write && (w_c_err == NO_MEM_ERROR);

  always_comb begin
    w_be = 4'b0000;
    w_ld = w_rd_sh;
    unique case (w_c_type)
      MEM_BYTE: begin
        w_be = 4'b0001 << w_lane;
        w_ld = {24'd0, w_rd_sh[7:0]};
      end
      MEM_HALF: begin
        w_be = 4'b0011 << w_lane;
        w_ld = {16'd0, w_rd_sh[15:0]};
      end
      MEM_WORD: w_be = 4'b1111;
      default:  w_be = 4'b0000;
    endcase
    if (w_c_write || (w_c_err != NO_MEM_ERROR))
      w_ld = 32'd0;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid)
                w_state_nx = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 3'd0) w_state_nx = S_RESP;
      S_RESP: if (rsp_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_type    <= MEM_BYTE;
      r_err     <= NO_MEM_ERROR;
      r_rdata   <= 32'd0;
      r_rsp_err <= NO_MEM_ERROR;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_write <= req_write;
        r_addr  <= req_addr[AW-1:0];
        r_wdata <= req_wdata;
        r_type  <= w_req_type;
        r_err   <= w_req_err;
      end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_commit) begin
        r_rdata   <= w_ld;
        r_rsp_err <= w_c_err;
      end
    end
  end

  // array is never reset; a store caught by reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wd_sh[8*b +: 8];
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors against LATENCY=1 and
// LATENCY=3 instances of data_mem_responder.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_type;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        a_req_ready, b_req_ready;
  logic        a_rsp_valid, b_rsp_valid;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic [1:0]  a_rsp_error, b_rsp_error;
  logic        a_req_valid, b_req_valid;

  logic        m_req_ready;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  m_rsp_error;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign m_rsp_error = sel ? b_rsp_error : a_rsp_error;

  data_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .req_wdata (req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_error (a_rsp_error)
  );

  data_mem_responder #(.MEM_WORDS(1024), .LATENCY(3)) u_dut_l3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .req_wdata (req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_error (b_rsp_error)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // lat counts cycles from the accept cycle (0) to the first valid cycle
  task automatic wait_rsp(output int lat);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [1:0] t, input logic [31:0] d,
                        output logic [31:0] rd, output logic [1:0] er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_type  = t;
    req_wdata = d;
    rsp_ready = 1'b1;
    n = 0;
    while (!m_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(m_req_ready), 32'd1);
    wait_rsp(lat);
    rd = m_rsp_rdata;
    er = m_rsp_error;
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          lat;
  logic        stable;

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_type  = 2'b00;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(m_req_ready), 32'd1);
    check("rst rsp_valid", 32'(m_rsp_valid), 32'd0);
    check("rst rsp_rdata", m_rsp_rdata, 32'd0);
    check("rst rsp_error", 32'(m_rsp_error), 32'd0);
    check("rst l3 ready", 32'(b_req_ready), 32'd1);
    rst_n = 1'b1;

    do_req(1'b1, 32'h10, 2'b10, 32'hDEADBEEF, rd, er, lat);
    check("sw lat", 32'(lat), 32'd2);
    check("sw rdata", rd, 32'd0);
    check("sw err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 2'b10, 32'd0, rd, er, lat);
    check("lw lat", 32'(lat), 32'd2);
    check("lw rdata", rd, 32'hDEADBEEF);
    check("lw err", 32'(er), 32'd0);

    do_req(1'b1, 32'h13, 2'b00, 32'h000000AA, rd, er, lat);
    check("sb err", 32'(er), 32'd0);
    do_req(1'b0, 32'h13, 2'b00, 32'd0, rd, er, lat);
    check("lbu 13", rd, 32'h000000AA);
    do_req(1'b0, 32'h10, 2'b10, 32'd0, rd, er, lat);
    check("lw after sb", rd, 32'hAAADBEEF);
    do_req(1'b1, 32'h10, 2'b01, 32'hFFFF1234, rd, er, lat);
    check("sh err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 2'b10, 32'd0, rd, er, lat);
    check("lw after sh", rd, 32'hAAAD1234);
    do_req(1'b0, 32'h12, 2'b01, 32'd0, rd, er, lat);
    check("lhu 12", rd, 32'h0000AAAD);

    do_req(1'b0, 32'h11, 2'b01, 32'd0, rd, er, lat);
    check("lh mis err", 32'(er), 32'd1);
    check("lh mis rdata", rd, 32'd0);
    do_req(1'b1, 32'h12, 2'b10, 32'hFFFFFFFF, rd, er, lat);
    check("sw mis err", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 2'b10, 32'd0, rd, er, lat);
    check("lw unchanged", rd, 32'hAAAD1234);
    do_req(1'b0, 32'h0, 2'b11, 32'd0, rd, er, lat);
    check("rsvd type err", 32'(er), 32'd1);

    do_req(1'b0, 32'h1000, 2'b10, 32'd0, rd, er, lat);
    check("oob err", 32'(er), 32'd2);
    check("oob rdata", rd, 32'd0);
    do_req(1'b0, 32'h1001, 2'b10, 32'd0, rd, er, lat);
    check("mis over oob", 32'(er), 32'd1);
    do_req(1'b1, 32'hFFF, 2'b00, 32'h0000005A, rd, er, lat);
    check("sb fff err", 32'(er), 32'd0);
    do_req(1'b0, 32'hFFF, 2'b00, 32'd0, rd, er, lat);
    check("lb fff err", 32'(er), 32'd0);
    check("lb fff rdata", rd, 32'h0000005A);

    do_req(1'b1, 32'h20, 2'b10, 32'h11223344, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_type  = 2'b10;
    req_wdata = 32'h00000055;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("wait ready", 32'(m_req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid rst valid", 32'(m_rsp_valid), 32'd0);
    check("mid rst ready", 32'(m_req_ready), 32'd1);
    do_req(1'b0, 32'h20, 2'b10, 32'd0, rd, er, lat);
    check("dropped store", rd, 32'h11223344);

    sel = 1'b1;
    do_req(1'b1, 32'h40, 2'b10, 32'hCAFEF00D, rd, er, lat);
    check("l3 sw lat", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    req_type  = 2'b10;
    rsp_ready = 1'b0;
    check("l3 lw ready", 32'(m_req_ready), 32'd1);
    wait_rsp(lat);
    check("l3 lw lat", 32'(lat), 32'd4);
    check("l3 lw rdata", m_rsp_rdata, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_addr  = 32'h40;
    req_type  = 2'b00;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_rsp_rdata !== 32'hCAFEF00D || m_rsp_error !== 2'b00 ||
          m_req_ready !== 1'b0 || m_rsp_valid !== 1'b1)
        stable = 1'b0;
    end
    check("l3 hold stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("l3 post hs ready", 32'(m_req_ready), 32'd1);
    check("l3 post hs valid", 32'(m_rsp_valid), 32'd0);
    wait_rsp(lat);
    check("l3 lb lat", 32'(lat), 32'd4);
    check("l3 lb rdata", m_rsp_rdata, 32'h0000000D);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
